// File: rtl/alu_share_ctrl.sv
// Shares one 32-bit ALU between two requesters: arbitrate, register operands, capture result, return on winner's channel.
// Optional build macro ALU_SHARE_FIXED_PRIO_EN selects fixed priority (requester 0 wins) instead of round-robin.
module alu_share_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_res,
  output logic        rsp0_zero,
  output logic        rsp0_ovf,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_res,
  output logic        rsp1_zero,
  output logic        rsp1_ovf,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_res,
  input  logic        alu_zero,
  input  logic        alu_ovf,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  state_t      state_next;
  logic        last_grant;
  logic        owner;
  logic        grant;
  logic        accept;
  logic [31:0] res_q;
  logic        zero_q;
  logic        ovf_q;

  // Winner among the currently valid requesters; only meaningful when at least one is valid.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = ~last_grant;
`endif
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign accept = (state == IDLE) && (req0_valid || req1_valid);

  // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          req0_ready = rst_n && !grant;
          req1_ready = rst_n && grant;
          state_next = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        rsp0_valid = !owner;
        rsp1_valid = owner;
        if (owner ? rsp1_ready : rsp0_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        owner      <= grant;
        last_grant <= grant;
      end
    end
  end

  // NOTE: the datapath registers are reset too, because their reset values are visible on the ALU and response ports.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (accept) begin
        alu_a  <= grant ? req1_a  : req0_a;
        alu_b  <= grant ? req1_b  : req0_b;
        alu_op <= grant ? req1_op : req0_op;
      end
      if (state == EXEC) begin
        res_q  <= alu_res;
        zero_q <= alu_zero;
        ovf_q  <= alu_ovf;
      end
    end
  end

  // Both channels see the shared capture registers; only valid is per channel.
  assign rsp0_res  = res_q;
  assign rsp0_zero = zero_q;
  assign rsp0_ovf  = ovf_q;
  assign rsp1_res  = res_q;
  assign rsp1_zero = zero_q;
  assign rsp1_ovf  = ovf_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: drivers push expected results per requester, a negedge monitor checks responses and arbitration.
module tb_alu_share_ctrl;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [31:0] rsp0_res, rsp1_res;
  logic        rsp0_zero, rsp0_ovf, rsp1_zero, rsp1_ovf;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [2:0]  alu_op;
  logic        alu_zero, alu_ovf;
  logic        busy;

  int checks = 0;
  int failures = 0;
  exp_t q0[$];
  exp_t q1[$];
  bit   pending [2];

  always #5 clk = ~clk;

  alu_share_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_res(rsp0_res), .rsp0_zero(rsp0_zero), .rsp0_ovf(rsp0_ovf),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_res(rsp1_res), .rsp1_zero(rsp1_zero), .rsp1_ovf(rsp1_ovf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .busy(busy)
  );

  // Reference ALU behaviour: signed overflow for add/sub, zero flag on the result.
  function automatic exp_t alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.ovf = 1'b0;
    case (op)
      3'b000: e.res = a & b;
      3'b001: e.res = a | b;
      3'b010: begin e.res = a + b; e.ovf = (a[31] == b[31]) && (e.res[31] != a[31]); end
      3'b011: e.res = a ^ b;
      3'b100: e.res = ~(a | b);
      3'b101: e.res = a >> b[4:0];
      3'b110: begin e.res = a - b; e.ovf = (a[31] != b[31]) && (e.res[31] != a[31]); end
      default: e.res = {31'd0, $signed(a) < $signed(b)};
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  exp_t alu_now;
  assign alu_now  = alu_model(alu_op, alu_a, alu_b);
  assign alu_res  = alu_now.res;
  assign alu_zero = alu_now.zero;
  assign alu_ovf  = alu_now.ovf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int n, input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
    else        begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
  endtask

  // Called at posedge+1; holds the request until accepted and returns at posedge+1 after the handshake.
  task automatic issue(input int n, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit got;
    got = 1'b0;
    if (n == 0) q0.push_back(alu_model(op, a, b));
    else        q1.push_back(alu_model(op, a, b));
    pending[n] = 1'b1;
    set_req(n, 1'b1, op, a, b);
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = (n == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready);
    end
    check("req_accept_timeout", 64'(got), 64'd1);
    @(posedge clk); #1;
    set_req(n, 1'b0, op, a, b);
    pending[n] = 1'b0;
  endtask

  task automatic issue_rand(input int n);
    issue(n, 3'($urandom_range(0, 7)), $urandom, $urandom);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = !busy && (q0.size() == 0) && (q1.size() == 0);
    end
    check("drain_to_idle", 64'(done), 64'd1);
    @(posedge clk); #1;
  endtask

  // Monitor: arbitration model, latency, ownership and scoreboard comparison.
  int   cyc = 0;
  int   accept_cyc = 0;
  bit   in_flight = 1'b0;
  bit   lat_checked = 1'b0;
  logic exp_owner = 1'b0;
  logic model_last = 1'b1;

  always @(negedge clk) begin
    logic n, g, m;
    exp_t e;
    cyc++;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      model_last  = 1'b1;
      in_flight   = 1'b0;
      lat_checked = 1'b0;
    end else begin
      check("ready_exclusive", 64'(req0_ready & req1_ready), 64'd0);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        n = req1_valid && req1_ready;
        check("unexpected_accept", 64'(pending[n]), 64'd1);
        if (req0_valid && req1_valid) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
          g = 1'b0;
`else
          g = ~model_last;
`endif
        end else begin
          g = req1_valid;
        end
        check("grant", 64'(n), 64'(g));
        check("no_bypass", 64'(rsp0_valid | rsp1_valid), 64'd0);
        model_last  = n;
        exp_owner   = n;
        accept_cyc  = cyc;
        in_flight   = 1'b1;
        lat_checked = 1'b0;
      end
      if (rsp0_valid || rsp1_valid) begin
        check("rsp_both_valid", 64'(rsp0_valid & rsp1_valid), 64'd0);
        if (!lat_checked) begin
          check("rsp_spurious", 64'(in_flight), 64'd1);
          check("rsp_latency", 64'(cyc - accept_cyc), 64'd2);
          check("rsp_owner", 64'(rsp1_valid), 64'(exp_owner));
          lat_checked = 1'b1;
        end
        if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
          m = rsp1_valid && rsp1_ready;
          if ((m ? q1.size() : q0.size()) == 0) begin
            check("rsp_queue_empty", 64'(m), 64'(!m));
          end else begin
            e = m ? q1.pop_front() : q0.pop_front();
            if (m) check("rsp1_data", 64'({rsp1_res, rsp1_zero, rsp1_ovf}), 64'(e));
            else   check("rsp0_data", 64'({rsp0_res, rsp0_zero, rsp0_ovf}), 64'(e));
          end
          in_flight   = 1'b0;
          lat_checked = 1'b0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    bit seen;
    bit rand_rsp;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_ready", 64'({req0_ready, req1_ready}), 64'd0);
    check("reset_rsp_valid", 64'({rsp0_valid, rsp1_valid}), 64'd0);
    check("reset_alu_drive", 64'({alu_a, alu_b} | 64'(alu_op)), 64'd0);
    check("reset_capture", 64'({rsp0_res, rsp0_zero, rsp0_ovf}), 64'd0);
    @(posedge clk); #1;

    // Directed operations from both requesters.
    issue(0, 3'b010, 32'd5, 32'd7);
    wait_idle();
    issue(1, 3'b110, 32'd3, 32'd3);
    issue(1, 3'b010, 32'h7FFF_FFFF, 32'd1);
    wait_idle();

    // Continuous contention, four operations each.
    fork
      for (int i = 0; i < 4; i++) issue_rand(0);
      for (int i = 0; i < 4; i++) issue_rand(1);
    join
    wait_idle();

    // Response backpressure; requester 1 shows up meanwhile and withdraws before being served.
    rsp0_ready = 1'b0;
    issue_rand(0);
    set_req(1, 1'b1, 3'b011, 32'hDEAD_BEEF, 32'h1234_5678);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = rsp0_valid;
    end
    check("stall_rsp_seen", 64'(seen), 64'd1);
    held = rsp0_res;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid_held", 64'(rsp0_valid), 64'd1);
      check("stall_res_stable", 64'(rsp0_res), 64'(held));
      check("stall_req1_blocked", 64'(req1_ready), 64'd0);
    end
    @(posedge clk); #1;
    set_req(1, 1'b0, 3'b011, 32'hDEAD_BEEF, 32'h1234_5678);
    rsp0_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_to_idle", 64'(busy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("dropped_req_idle", 64'(busy), 64'd0);
    end
    @(posedge clk); #1;

    // Reset while the operation is executing.
    issue_rand(0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_rsp", 64'({rsp0_valid, rsp1_valid}), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_alu_drive", 64'({alu_a, alu_b} | 64'(alu_op)), 64'd0);
    end
    @(posedge clk); #1;
    fork
      issue_rand(0);
      issue_rand(1);
    join
    wait_idle();

    // Randomized traffic with random response backpressure.
    rand_rsp = 1'b1;
    fork
      begin
        fork
          for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            issue_rand(0);
          end
          for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            issue_rand(1);
          end
        join
        rand_rsp = 1'b0;
      end
      while (rand_rsp) begin
        @(posedge clk); #1;
        rsp0_ready = 1'($urandom_range(0, 1));
        rsp1_ready = 1'($urandom_range(0, 1));
      end
    join
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
